// File: rtl/control_unit_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_unit_pipe_pkg
// Description : Shared RV32I decode definitions for the registered ID/EX
//               control unit: opcodes, ALU op encodings, the packed control
//               word and the front-end sequencing states.
//               Optional macro CTRL_SYSTEM_EN adds the csr control field.
// Revision    : 1.0 - initial release
// ============================================================================
package control_unit_pipe_pkg;

    localparam int OPCODE_SIZE = 7;
    localparam int ALU_OP_SIZE = 3;

    // RV32I major opcodes
    localparam logic [OPCODE_SIZE-1:0] OPC_R      = 7'b0110011;
    localparam logic [OPCODE_SIZE-1:0] OPC_I      = 7'b0010011;
    localparam logic [OPCODE_SIZE-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPCODE_SIZE-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPCODE_SIZE-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPCODE_SIZE-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPCODE_SIZE-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPCODE_SIZE-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPCODE_SIZE-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_SIZE-1:0] OPC_SYSTEM = 7'b1110011;

    // ALU operation classes handed to EX
    localparam logic [ALU_OP_SIZE-1:0] ALUOP_IMM    = 3'b000;
    localparam logic [ALU_OP_SIZE-1:0] ALUOP_STORE  = 3'b001;
    localparam logic [ALU_OP_SIZE-1:0] ALUOP_UPPER  = 3'b010;
    localparam logic [ALU_OP_SIZE-1:0] ALUOP_BRANCH = 3'b011;
    localparam logic [ALU_OP_SIZE-1:0] ALUOP_JUMP   = 3'b100;
    localparam logic [ALU_OP_SIZE-1:0] ALUOP_REG    = 3'b101;
    localparam logic [ALU_OP_SIZE-1:0] ALUOP_LOAD   = 3'b110;

    // Width of the front-end flush counter
    localparam int FLUSH_CNT_W = 4;

    typedef struct packed {
        logic                   jump_reg;
        logic                   jump;
        logic                   branch;
        logic                   reg_src1;
        logic                   reg_src2;
        logic                   upper_imm;
        logic                   reg_write;
        logic                   mem_write;
        logic                   mem_to_reg;
        logic                   ret_addr;
        logic                   imm;
        logic                   rvfi_i;
`ifdef CTRL_SYSTEM_EN
        logic                   csr;
`endif
        logic [ALU_OP_SIZE-1:0] alu_op;
    } ctrl_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        TRAP  = 2'd2
    } ctrl_state_t;

endpackage : control_unit_pipe_pkg
`default_nettype wire

// File: rtl/control_unit_pipe_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Pure combinational opcode decoder producing the control word,
//               an illegal-opcode flag and a front-end redirect flag.
//               Optional macro CTRL_SYSTEM_EN makes SYSTEM a legal redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import control_unit_pipe_pkg::*;
#(
    parameter int OPCODE_W = 7
) (
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl,
    output logic                illegal,
    output logic                redirect
);

    // Opcode to control word lookup; unknown opcodes yield an all-zero word
    always_comb begin
        ctrl     = '0;
        illegal  = 1'b0;
        redirect = 1'b0;
        case (opcode)
            OPC_R: begin
                ctrl.reg_src1  = 1'b1;
                ctrl.reg_src2  = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.rvfi_i    = 1'b1;
                ctrl.alu_op    = ALUOP_REG;
            end
            OPC_I: begin
                ctrl.reg_src1  = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.imm       = 1'b1;
                ctrl.rvfi_i    = 1'b1;
                ctrl.alu_op    = ALUOP_IMM;
            end
            OPC_LOAD: begin
                ctrl.reg_src1   = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.imm        = 1'b1;
                ctrl.rvfi_i     = 1'b1;
                ctrl.alu_op     = ALUOP_LOAD;
            end
            OPC_STORE: begin
                ctrl.reg_src1  = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.imm       = 1'b1;
                ctrl.rvfi_i    = 1'b1;
                ctrl.alu_op    = ALUOP_STORE;
            end
            OPC_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.reg_src1 = 1'b1;
                ctrl.reg_src2 = 1'b1;
                ctrl.rvfi_i   = 1'b1;
                ctrl.alu_op   = ALUOP_BRANCH;
            end
            OPC_JALR: begin
                ctrl.jump      = 1'b1;
                ctrl.jump_reg  = 1'b1;
                ctrl.branch    = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.ret_addr  = 1'b1;
                ctrl.rvfi_i    = 1'b1;
                ctrl.alu_op    = ALUOP_JUMP;
                redirect       = 1'b1;
            end
            OPC_JAL: begin
                ctrl.jump      = 1'b1;
                ctrl.branch    = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.ret_addr  = 1'b1;
                ctrl.rvfi_i    = 1'b1;
                ctrl.alu_op    = ALUOP_JUMP;
                redirect       = 1'b1;
            end
            OPC_LUI: begin
                ctrl.upper_imm = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.imm       = 1'b1;
                ctrl.rvfi_i    = 1'b1;
                ctrl.alu_op    = ALUOP_UPPER;
            end
            OPC_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.imm       = 1'b1;
                ctrl.rvfi_i    = 1'b1;
                ctrl.alu_op    = ALUOP_UPPER;
            end
`ifdef CTRL_SYSTEM_EN
            OPC_SYSTEM: begin
                ctrl.csr       = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.reg_src1  = 1'b1;
                ctrl.imm       = 1'b1;
                ctrl.rvfi_i    = 1'b1;
                ctrl.alu_op    = ALUOP_IMM;
                // CSR side effects may change fetch context, so refetch
                redirect       = 1'b1;
            end
`endif
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/control_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : control_unit_pipe
// Description : Registered, stall-aware ID/EX control unit. Decodes the ID
//               opcode, registers the control word into EX behind a
//               valid/ready handshake, sequences front-end flushes after
//               jumps and taken branches, and holds illegal-opcode traps
//               until acknowledged.
//               Optional macro CTRL_SYSTEM_EN enables the SYSTEM opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit_pipe
    import control_unit_pipe_pkg::*;
#(
    parameter int OPCODE_W     = 7,
    parameter int ALUOP_W      = 3,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [OPCODE_W-1:0] id_opcode,
    output logic                id_ready,
    output logic                ex_valid,
    input  logic                ex_ready,
    output ctrl_t               ex_ctrl,
    input  logic                ex_branch_taken,
    output logic                id_flush,
    output logic                trap_req,
    input  logic                trap_ack
);

    localparam logic [FLUSH_CNT_W-1:0] c_FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

    // Reject configurations the control word or counter cannot represent
    generate
        if (ALUOP_W != ALU_OP_SIZE || OPCODE_W != OPCODE_SIZE) begin : g_width_check
            $error("control_unit_pipe: OPCODE_W/ALUOP_W must match the package widths");
        end
        if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_flush_check
            $error("control_unit_pipe: FLUSH_CYCLES must lie in 1..15");
        end
    endgenerate

    ctrl_state_t              r_state;
    ctrl_state_t              w_state_nxt;
    logic [FLUSH_CNT_W-1:0]   r_flush_cnt;
    logic [FLUSH_CNT_W-1:0]   w_flush_cnt_nxt;
    logic                     r_ex_valid;
    logic                     w_ex_valid_nxt;
    ctrl_t                    r_ex_ctrl;
    ctrl_t                    w_ex_ctrl_nxt;

    ctrl_t                    w_dec_ctrl;
    logic                     w_dec_illegal;
    logic                     w_dec_redirect;
    logic                     w_ex_free;

    ctrl_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .opcode   (id_opcode),
        .ctrl     (w_dec_ctrl),
        .illegal  (w_dec_illegal),
        .redirect (w_dec_redirect)
    );

    // EX slot can take a new word when empty or being consumed this cycle
    assign w_ex_free = !r_ex_valid || ex_ready;

    assign ex_valid = r_ex_valid;
    assign ex_ctrl  = r_ex_ctrl;

    // Next-state, counter, EX register and handshake outputs
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_ex_valid_nxt  = r_ex_valid;
        w_ex_ctrl_nxt   = r_ex_ctrl;
        id_ready        = w_ex_free;
        id_flush        = 1'b0;
        trap_req        = 1'b0;

        // Whenever EX frees up and nothing is accepted, a bubble moves in
        if (w_ex_free) begin
            w_ex_valid_nxt = 1'b0;
            w_ex_ctrl_nxt  = '0;
        end

        case (r_state)
            RUN: begin
                if (ex_branch_taken) begin
                    // The ID instruction is on the wrong path: drop it
                    w_state_nxt     = FLUSH;
                    w_flush_cnt_nxt = c_FLUSH_LOAD;
                end else if (id_valid && w_ex_free) begin
                    if (w_dec_illegal) begin
                        w_state_nxt = TRAP;
                    end else begin
                        w_ex_valid_nxt = 1'b1;
                        w_ex_ctrl_nxt  = w_dec_ctrl;
                        if (w_dec_redirect) begin
                            w_state_nxt     = FLUSH;
                            w_flush_cnt_nxt = c_FLUSH_LOAD;
                        end
                    end
                end
            end
            FLUSH: begin
                id_flush = 1'b1;
                id_ready = 1'b1;
                if (ex_branch_taken) begin
                    w_flush_cnt_nxt = c_FLUSH_LOAD;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 1'b1;
                    if (r_flush_cnt <= FLUSH_CNT_W'(1)) begin
                        w_flush_cnt_nxt = '0;
                        w_state_nxt     = RUN;
                    end
                end
            end
            TRAP: begin
                trap_req = 1'b1;
                id_flush = 1'b1;
                id_ready = 1'b0;
                if (trap_ack) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt     = RUN;
                w_flush_cnt_nxt = '0;
            end
        endcase
    end

    // State, flush counter and EX pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
            r_ex_valid  <= 1'b0;
            r_ex_ctrl   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_ex_valid  <= w_ex_valid_nxt;
            r_ex_ctrl   <= w_ex_ctrl_nxt;
        end
    end

endmodule : control_unit_pipe
`default_nettype wire

// File: tb/tb_control_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit_pipe
// Description : Self-checking bench for control_unit_pipe: decode table,
//               stall, flush, trap and reset sequences, then random traffic
//               against a behavioural reference model.
//               Honours CTRL_SYSTEM_EN when it is defined for the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit_pipe;
    import control_unit_pipe_pkg::*;

    localparam int FC = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic       id_ready;
    logic       ex_valid;
    logic       ex_ready;
    ctrl_t      ex_ctrl;
    logic       ex_branch_taken;
    logic       id_flush;
    logic       trap_req;
    logic       trap_ack;

    always #5 clk = ~clk;

    control_unit_pipe #(
        .OPCODE_W     (7),
        .ALUOP_W      (3),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_opcode       (id_opcode),
        .id_ready        (id_ready),
        .ex_valid        (ex_valid),
        .ex_ready        (ex_ready),
        .ex_ctrl         (ex_ctrl),
        .ex_branch_taken (ex_branch_taken),
        .id_flush        (id_flush),
        .trap_req        (trap_req),
        .trap_ack        (trap_ack)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Decode vector table
    typedef struct {
        logic [6:0] opc;
        bit         legal;
        ctrl_t      ctrl;
    } dec_vec_t;
    dec_vec_t tbl[$];

    // Reference model: cycles of flush left, trap pending, EX contents
    int    m_flush_left;
    bit    m_trapped;
    bit    m_ex_v;
    ctrl_t m_ex_c;

    task automatic add(input logic [6:0] opc, input bit legal, input ctrl_t c);
        dec_vec_t v;
        v.opc = opc; v.legal = legal; v.ctrl = c;
        tbl.push_back(v);
    endtask

    task automatic build_table();
        ctrl_t c;
        c = '0; c.reg_src1 = 1; c.reg_src2 = 1; c.reg_write = 1; c.rvfi_i = 1; c.alu_op = 3'b101;
        add(7'b0110011, 1, c);
        c = '0; c.reg_src1 = 1; c.reg_write = 1; c.imm = 1; c.rvfi_i = 1; c.alu_op = 3'b000;
        add(7'b0010011, 1, c);
        c = '0; c.reg_src1 = 1; c.reg_write = 1; c.mem_to_reg = 1; c.imm = 1; c.rvfi_i = 1; c.alu_op = 3'b110;
        add(7'b0000011, 1, c);
        c = '0; c.reg_src1 = 1; c.mem_write = 1; c.imm = 1; c.rvfi_i = 1; c.alu_op = 3'b001;
        add(7'b0100011, 1, c);
        c = '0; c.branch = 1; c.reg_src1 = 1; c.reg_src2 = 1; c.rvfi_i = 1; c.alu_op = 3'b011;
        add(7'b1100011, 1, c);
        c = '0; c.jump = 1; c.jump_reg = 1; c.branch = 1; c.reg_write = 1; c.ret_addr = 1; c.rvfi_i = 1; c.alu_op = 3'b100;
        add(7'b1100111, 1, c);
        c.jump_reg = 0;
        add(7'b1101111, 1, c);
        c = '0; c.upper_imm = 1; c.reg_write = 1; c.imm = 1; c.rvfi_i = 1; c.alu_op = 3'b010;
        add(7'b0110111, 1, c);
        c = '0; c.reg_write = 1; c.imm = 1; c.rvfi_i = 1; c.alu_op = 3'b010;
        add(7'b0010111, 1, c);
`ifdef CTRL_SYSTEM_EN
        c = '0; c.csr = 1; c.reg_write = 1; c.reg_src1 = 1; c.imm = 1; c.rvfi_i = 1; c.alu_op = 3'b000;
        add(7'b1110011, 1, c);
`else
        add(7'b1110011, 0, '0);
`endif
        add(7'b1111111, 0, '0);
        add(7'b0000000, 0, '0);
        add(7'b0001111, 0, '0);
    endtask

    function automatic bit lookup(input logic [6:0] opc, output ctrl_t c);
        c = '0;
        foreach (tbl[i]) begin
            if (tbl[i].opc == opc) begin
                c = tbl[i].ctrl;
                return tbl[i].legal;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit is_redirect(input ctrl_t c);
`ifdef CTRL_SYSTEM_EN
        return c.jump || c.csr;
`else
        return c.jump;
`endif
    endfunction

    task automatic model_reset();
        m_flush_left = 0;
        m_trapped    = 0;
        m_ex_v       = 0;
        m_ex_c       = '0;
    endtask

    // Advance the model across one rising edge using the current inputs
    task automatic model_edge();
        bit    ex_free;
        bit    legal;
        ctrl_t c;
        ex_free = !m_ex_v || ex_ready;
        if (ex_free) begin
            m_ex_v = 0;
            m_ex_c = '0;
        end
        if (m_trapped) begin
            if (trap_ack) m_trapped = 0;
        end else if (m_flush_left > 0) begin
            m_flush_left = ex_branch_taken ? FC : m_flush_left - 1;
        end else if (ex_branch_taken) begin
            m_flush_left = FC;
        end else if (id_valid && ex_free) begin
            legal = lookup(id_opcode, c);
            if (!legal) begin
                m_trapped = 1;
            end else begin
                m_ex_v = 1;
                m_ex_c = c;
                if (is_redirect(c)) m_flush_left = FC;
            end
        end
    endtask

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        bit exp_ready;
        exp_ready = m_trapped ? 1'b0 : (m_flush_left > 0) ? 1'b1 : (!m_ex_v || ex_ready);
        cmp("id_ready", id_ready, exp_ready);
        cmp("id_flush", id_flush, m_trapped || (m_flush_left > 0));
        cmp("trap_req", trap_req, m_trapped);
        cmp("ex_valid", ex_valid, m_ex_v);
        cmp("ex_ctrl", ex_ctrl, m_ex_c);
    endtask

    task automatic drive(input bit v, input logic [6:0] opc, input bit rdy, input bit br, input bit ack);
        id_valid        = v;
        id_opcode       = opc;
        ex_ready        = rdy;
        ex_branch_taken = br;
        trap_ack        = ack;
    endtask

    // Called 1 time unit after a falling edge with inputs settled
    task automatic tick();
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic step();
        #1;
        tick();
    endtask

    // Idle until the model is back in normal running
    task automatic settle();
        for (int i = 0; i < 40 && (m_trapped || m_flush_left > 0); i++) begin
            drive(0, '0, 1, 0, m_trapped);
            step();
        end
        if (m_trapped || m_flush_left > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL settle: model did not return to run within bound");
        end
        drive(0, '0, 1, 0, 0);
        step();
    endtask

    initial begin
        ctrl_t c_load;
        ctrl_t c_r;
        ctrl_t tmp;
        bit    ok;
        int    nf;
        build_table();
        ok = lookup(7'b0000011, c_load);
        ok = lookup(7'b0110011, c_r);

        // Reset values while reset is held
        reset = 1'b1;
        drive(0, '0, 1, 0, 0);
        model_reset();
        @(negedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
        step();

        // Decode table
        for (int i = 0; i < tbl.size(); i++) begin
            drive(1, tbl[i].opc, 1, 0, 0);
            step();
            cmp("dec_valid", ex_valid, tbl[i].legal);
            cmp("dec_ctrl", ex_ctrl, tbl[i].legal ? tbl[i].ctrl : '0);
            cmp("dec_trap", trap_req, !tbl[i].legal);
            settle();
        end

        // LOAD held in EX for 3 stalled cycles, then released
        drive(1, 7'b0000011, 1, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 7'b0110011, 0, 0, 0);
            #1;
            cmp("stall_ready", id_ready, 0);
            tick();
            cmp("stall_hold", ex_ctrl, c_load);
        end
        drive(1, 7'b0110011, 1, 0, 0);
        step();
        cmp("stall_release", ex_ctrl, c_r);
        settle();

        // JAL: ret_addr registered, exactly FC flush cycles, STORE discarded
        drive(1, 7'b1101111, 1, 0, 0);
        step();
        cmp("jal_ret_addr", ex_ctrl.ret_addr, 1);
        nf = 0;
        for (int i = 0; i < FC + 4; i++) begin
            drive(1, 7'b0100011, 1, 0, 0);
            #1;
            if (!id_flush) break;
            nf++;
            tick();
            cmp("flush_no_store", ex_valid, 0);
        end
        cmp("jal_flush_len", nf, FC);
        drive(0, '0, 1, 0, 0);
        step();
        settle();

        // Taken branch beats an illegal opcode in the same cycle
        drive(1, 7'b1111111, 1, 1, 0);
        step();
        cmp("br_wins_trap", trap_req, 0);
        cmp("br_wins_flush", id_flush, 1);
        settle();

        // Illegal opcode holds the trap until acknowledged
        drive(1, 7'b1111111, 1, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 7'b0110011, 1, 1, 0);
            #1;
            cmp("trap_hold_req", trap_req, 1);
            cmp("trap_hold_ready", id_ready, 0);
            tick();
            cmp("trap_no_ex", ex_valid, 0);
        end
        drive(0, '0, 1, 0, 1);
        step();
        cmp("trap_ack_run", trap_req, 0);
        settle();

        // Asynchronous reset in the middle of a flush
        drive(1, 7'b1101111, 1, 0, 0);
        step();
        drive(0, '0, 1, 0, 0);
        step();
        cmp("pre_reset_flush", id_flush, 1);
        reset = 1'b1;
        #1;
        cmp("async_flush", id_flush, 0);
        cmp("async_valid", ex_valid, 0);
        cmp("async_trap", trap_req, 0);
        cmp("async_ready", id_ready, 1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step();

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic [6:0] opc;
            if ($urandom_range(0, 4) == 0) opc = 7'($urandom);
            else opc = tbl[$urandom_range(0, tbl.size() - 1)].opc;
            drive($urandom_range(0, 3) != 0, opc, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
            step();
        end
        ok = lookup(7'b0, tmp);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_control_unit_pipe
`default_nettype wire
